// File: rtl/pll_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pll_seq_pkg
//  Purpose  : Shared types, default timing constants and output decode for
//             the PLL reset sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package pll_seq_pkg;

  // Sequencer states; the numeric values are visible on the state port.
  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_state_t;

  // Default timing for a 50 MHz reference clock.
  localparam int c_def_pll_rst_cycles     = 16;
  localparam int c_def_lock_timeout       = 50000;
  localparam int c_def_lock_stable_cycles = 1024;
  localparam int c_def_max_retries        = 3;
  localparam int c_def_cnt_w              = 17;

  // Registered control outputs, bundled so they are always written together.
  typedef struct packed {
    logic pll_rst;
    logic sys_rst;
    logic ready;
    logic fail;
  } seq_out_t;

  // Output levels that belong to each state.
  function automatic seq_out_t decode_outputs(input pll_state_t s);
    seq_out_t o;
    o.pll_rst = (s == ST_HOLD) || (s == ST_FAIL);
    o.sys_rst = (s != ST_RUN);
    o.ready   = (s == ST_RUN);
    o.fail    = (s == ST_FAIL);
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Parameterised-width double-flop synchroniser for asynchronous
//             status inputs. Adds two destination-clock cycles of latency.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two-stage capture; the first stage may go metastable, the second settles it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pll_reset_sequencer
//  Purpose  : Drives the PLL reset, waits for a stable lock with a timeout and
//             bounded retries, and releases the fabric reset only while the
//             PLL is stably locked.
//  Revision : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES     = c_def_pll_rst_cycles,
  parameter int LOCK_TIMEOUT       = c_def_lock_timeout,
  parameter int LOCK_STABLE_CYCLES = c_def_lock_stable_cycles,
  parameter int MAX_RETRIES        = c_def_max_retries,
  parameter int CNT_W              = c_def_cnt_w
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [1:0] retries,
  output logic [2:0] state
);

  // Terminal counts: each state acts on the edge where the counter shows N-1.
  localparam logic [CNT_W-1:0] c_hold_last    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_stable_last  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [1:0]       c_max_retries  = 2'(MAX_RETRIES);

  pll_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_retries;
  logic             r_lock_lost;
  seq_out_t         r_out;

  logic             w_locked_s;
  logic [CNT_W-1:0] w_cnt_sat;

  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (w_locked_s)
  );

  // Saturating increment so a long stay in any state can never wrap the count.
  assign w_cnt_sat = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

  // Sequencer FSM; outputs are registered alongside each state change.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state     <= ST_HOLD;
      r_cnt       <= '0;
      r_retries   <= '0;
      r_lock_lost <= 1'b0;
      r_out       <= decode_outputs(ST_HOLD);
    end else if (restart) begin
      // A soft restart outranks a simultaneous lock drop, so lock_lost clears.
      r_state     <= ST_HOLD;
      r_cnt       <= '0;
      r_retries   <= '0;
      r_lock_lost <= 1'b0;
      r_out       <= decode_outputs(ST_HOLD);
    end else begin
      r_cnt <= w_cnt_sat;
      case (r_state)
        ST_HOLD: begin
          if (r_cnt == c_hold_last) begin
            r_state <= ST_WAIT_LOCK;
            r_out   <= decode_outputs(ST_WAIT_LOCK);
            r_cnt   <= '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (w_locked_s) begin
            r_state <= ST_STABLE;
            r_out   <= decode_outputs(ST_STABLE);
            r_cnt   <= '0;
          end else if (r_cnt == c_timeout_last) begin
            r_cnt <= '0;
            if (r_retries < c_max_retries) begin
              r_retries <= r_retries + 2'd1;
              r_state   <= ST_HOLD;
              r_out     <= decode_outputs(ST_HOLD);
            end else begin
              r_state <= ST_FAIL;
              r_out   <= decode_outputs(ST_FAIL);
            end
          end
        end
        ST_STABLE: begin
          // A lock glitch restarts the timeout but does not cost a retry.
          if (!w_locked_s) begin
            r_state <= ST_WAIT_LOCK;
            r_out   <= decode_outputs(ST_WAIT_LOCK);
            r_cnt   <= '0;
          end else if (r_cnt == c_stable_last) begin
            r_state <= ST_RUN;
            r_out   <= decode_outputs(ST_RUN);
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          if (!w_locked_s) begin
            r_lock_lost <= 1'b1;
            r_retries   <= '0;
            r_state     <= ST_HOLD;
            r_out       <= decode_outputs(ST_HOLD);
            r_cnt       <= '0;
          end
        end
        ST_FAIL: begin
          // Terminal until rst or restart; hold the counter still.
          r_cnt <= r_cnt;
        end
        default: begin
          r_state <= ST_HOLD;
          r_out   <= decode_outputs(ST_HOLD);
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign pll_rst   = r_out.pll_rst;
  assign sys_rst   = r_out.sys_rst;
  assign ready     = r_out.ready;
  assign fail      = r_out.fail;
  assign lock_lost = r_lock_lost;
  assign retries   = r_retries;
  assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pll_reset_sequencer
//  Purpose  : Self-checking bench for pll_reset_sequencer with a small
//             behavioural reference model and directed scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

  localparam int P = 4;    // PLL reset hold
  localparam int T = 20;   // lock timeout
  localparam int S = 8;    // stability window
  localparam int M = 3;    // extra retries

  // Phase numbers as they appear on the state port.
  localparam int PH_HOLD   = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_STABLE = 2;
  localparam int PH_RUN    = 3;
  localparam int PH_FAIL   = 4;

  logic       refclk  = 1'b0;
  logic       rst     = 1'b1;
  logic       locked  = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic       lock_lost;
  logic [1:0] retries;
  logic [2:0] state;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES     (P),
    .LOCK_TIMEOUT       (T),
    .LOCK_STABLE_CYCLES (S),
    .MAX_RETRIES        (M),
    .CNT_W              (17)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .locked    (locked),
    .restart   (restart),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .ready     (ready),
    .fail      (fail),
    .lock_lost (lock_lost),
    .retries   (retries),
    .state     (state)
  );

  always #5 refclk = ~refclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Time in a phase is measured as edges elapsed since the entering edge.
  int m_edge    = 0;
  int m_enter   = 0;
  int m_phase   = PH_HOLD;
  int m_retries = 0;
  bit m_lost    = 1'b0;
  bit m_valid   = 1'b0;
  bit lq[$];      // raw lock samples; lq[0] is the one two edges old

  task automatic model_step(input bit r, input bit rs, input bit lk);
    bit ls;
    int el;
    m_edge++;
    if (r) begin
      m_phase = PH_HOLD; m_enter = m_edge; m_retries = 0; m_lost = 1'b0;
      lq.delete(); lq.push_back(1'b0); lq.push_back(1'b0);
    end else begin
      ls = lq[0];
      void'(lq.pop_front());
      lq.push_back(lk);
      el = m_edge - m_enter;
      if (rs) begin
        m_phase = PH_HOLD; m_enter = m_edge; m_retries = 0; m_lost = 1'b0;
      end else if (m_phase == PH_HOLD) begin
        if (el == P) begin m_phase = PH_WAIT; m_enter = m_edge; end
      end else if (m_phase == PH_WAIT) begin
        if (ls) begin
          m_phase = PH_STABLE; m_enter = m_edge;
        end else if (el == T) begin
          if (m_retries < M) begin
            m_retries++; m_phase = PH_HOLD; m_enter = m_edge;
          end else begin
            m_phase = PH_FAIL;
          end
        end
      end else if (m_phase == PH_STABLE) begin
        if (!ls) begin m_phase = PH_WAIT; m_enter = m_edge; end
        else if (el == S) begin m_phase = PH_RUN; m_enter = m_edge; end
      end else if (m_phase == PH_RUN) begin
        if (!ls) begin
          m_lost = 1'b1; m_retries = 0; m_phase = PH_HOLD; m_enter = m_edge;
        end
      end
    end
  endtask

  // Compare every output against the model once per cycle.
  always @(negedge refclk) begin
    if (m_valid) begin
      check("m_pll_rst",   pll_rst,   (m_phase == PH_HOLD) || (m_phase == PH_FAIL));
      check("m_sys_rst",   sys_rst,   (m_phase != PH_RUN));
      check("m_ready",     ready,     (m_phase == PH_RUN));
      check("m_fail",      fail,      (m_phase == PH_FAIL));
      check("m_lock_lost", lock_lost, m_lost);
      check("m_retries",   retries,   m_retries);
      check("m_state",     state,     m_phase);
    end
  end

  // One clock: model advances on the edge, inputs may change after negedge.
  task automatic cyc();
    @(posedge refclk);
    model_step(rst, restart, locked);
    m_valid = 1'b1;
    @(negedge refclk);
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Reset state
    rst = 1'b1; locked = 1'b1; restart = 1'b0;
    cyc(); cyc();
    check("rst_pll_rst", pll_rst, 1);
    check("rst_sys_rst", sys_rst, 1);
    check("rst_ready",   ready,   0);
    check("rst_state",   state,   0);
    rst = 1'b0;

    // 1: normal lock
    run(3);  check("t1_pll_rst_e3", pll_rst, 1);
    run(1);  check("t1_pll_rst_e4", pll_rst, 0); check("t1_state_e4", state, 1);
    run(8);  check("t1_ready_e12", ready, 0);    check("t1_state_e12", state, 2);
    run(1);  check("t1_ready_e13", ready, 1);    check("t1_sys_rst_e13", sys_rst, 0);
    check("t1_state_e13", state, 3);

    // 2: no lock, retries exhausted
    rst = 1'b1; locked = 1'b0; cyc(); cyc(); rst = 1'b0;
    run(24); check("t2_retries_e24", retries, 1); check("t2_state_e24", state, 0);
    run(71); check("t2_fail_e95", fail, 0);       check("t2_retries_e95", retries, 3);
    run(1);  check("t2_fail_e96", fail, 1);       check("t2_state_e96", state, 4);
    check("t2_pll_rst_e96", pll_rst, 1);
    run(5);  check("t2_fail_hold", fail, 1);      check("t2_retries_hold", retries, 3);
    restart = 1'b1; run(1); restart = 1'b0;
    check("t2_fail_restart", fail, 0); check("t2_state_restart", state, 0);

    // 3: glitchy lock during the stability window
    locked = 1'b1;
    run(5);  check("t3_state_stable", state, 2);
    run(3);  locked = 1'b0;
    run(3);  check("t3_state_back", state, 1); check("t3_retries", retries, 0);
    check("t3_ready", ready, 0);
    locked = 1'b1;
    run(3);  check("t3_state_stable2", state, 2);
    run(7);  check("t3_ready_early", ready, 0);
    run(1);  check("t3_ready", ready, 1); check("t3_state_run", state, 3);

    // 4: one-cycle lock loss while running
    locked = 1'b0; run(1); locked = 1'b1;
    run(1);  check("t4_ready_e2", ready, 1); check("t4_lost_e2", lock_lost, 0);
    run(1);  check("t4_ready_e3", ready, 0); check("t4_sys_rst_e3", sys_rst, 1);
    check("t4_lost_e3", lock_lost, 1); check("t4_state_e3", state, 0);
    run(12); check("t4_ready_e15", ready, 0);
    run(1);  check("t4_ready_e16", ready, 1); check("t4_lost_e16", lock_lost, 1);

    // 5a: restart coincident with the synchronised lock drop
    locked = 1'b0; run(1); locked = 1'b1;
    run(1);  restart = 1'b1;
    run(1);  restart = 1'b0;
    check("t5_state", state, 0); check("t5_lost", lock_lost, 0);
    check("t5_ready", ready, 0);
    run(12); check("t5_state_e15", state, 2);
    run(1);  check("t5_state_e16", state, 3);

    // 5b: rst asserted mid-stability window
    restart = 1'b1; run(1); restart = 1'b0;
    run(7);  check("t5b_state_stable", state, 2);
    rst = 1'b1; run(1);
    check("t5b_pll_rst", pll_rst, 1); check("t5b_sys_rst", sys_rst, 1);
    check("t5b_state", state, 0);     check("t5b_ready", ready, 0);
    rst = 1'b0;
    run(13); check("t5b_ready_again", ready, 1);

    run(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Controller for the system PLL. It drives the PLL reset input, monitors the PLL `locked` output, enforces a lock-stability window, and retries with a timeout when lock is not achieved.
- It releases the fabric system reset only when the PLL is stably locked, and re-asserts that reset if lock is lost.
- Sits between the board reset/refclk domain and the PLL instance, alongside the PLL wrapper at SoC top level.

Parameters:
- PLL_RST_CYCLES, 16: refclk cycles the PLL reset is held high per attempt.
- LOCK_TIMEOUT, 50000: cycles to wait for lock per attempt (1 ms at 50 MHz).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release.
- MAX_RETRIES, 3: extra attempts after the first timeout before declaring failure.
- CNT_W, 17: shared cycle-counter width. Must hold max(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES).

Ports:
- refclk, input, 1: 50 MHz reference clock; the only clock.
- rst, input, 1: synchronous, active-high reset.
- locked, input, 1: PLL lock indicator; asynchronous to refclk.
- restart, input, 1: single-cycle soft restart request.
- pll_rst, output, 1: reset to the PLL; active-high.
- sys_rst, output, 1: fabric reset; active-high.
- ready, output, 1: PLL stably locked, system running.
- fail, output, 1: retries exhausted.
- lock_lost, output, 1: sticky flag; lock dropped while in RUN.
- retries, output, 2: attempts consumed in the current sequence.
- state, output, 3: current FSM state encoding.

Behaviour:
- All outputs are registered and decoded from the state register and counters. There is no combinational path from any input to any output.
- locked passes through a 2-flop synchronizer to form locked_s, adding 2 cycles of latency.
- Reset (rst=1) forces: state=HOLD, counter=0, retries=0, lock_lost=0, pll_rst=1, sys_rst=1, ready=0, fail=0.
- HOLD (pll_rst=1, sys_rst=1): counts PLL_RST_CYCLES cycles, then moves to WAIT_LOCK and clears the counter.
- WAIT_LOCK (pll_rst=0, sys_rst=1):
  - locked_s=1: move to STABLE, counter=0.
  - counter reaches LOCK_TIMEOUT-1 with no lock and retries<MAX_RETRIES: retries+1, move to HOLD.
  - counter reaches LOCK_TIMEOUT-1 with no lock and retries==MAX_RETRIES: move to FAIL.
- STABLE (pll_rst=0, sys_rst=1):
  - locked_s=0: move to WAIT_LOCK, counter=0. The timeout restarts; retries is unchanged.
  - counter reaches LOCK_STABLE_CYCLES-1 with lock held: move to RUN.
- RUN (pll_rst=0, sys_rst=0, ready=1):
  - locked_s=0: set lock_lost, retries=0, move to HOLD. sys_rst=1 and ready=0 on the next edge.
- FAIL (pll_rst=1, sys_rst=1, fail=1): terminal; exits only via rst or restart.
- restart=1 in any state: move to HOLD, counter=0, retries=0, clear fail and lock_lost.
  - restart and a locked_s drop in the same cycle: restart wins; lock_lost stays clear.
- rst has priority over restart.
- Timing, with locked held high from reset (edge 1 = first edge with rst=0):
  - pll_rst falls after edge PLL_RST_CYCLES.
  - ready rises after edge PLL_RST_CYCLES+LOCK_STABLE_CYCLES+1.
- The counter saturates; it never wraps within a state.
- retries never exceeds MAX_RETRIES.

Decomposition:
- Shared package pll_seq_pkg holds the state enumeration (HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4) and the default timing constants.
- Sub-module sync_2ff: parameterized-width double-flop synchronizer. It is reusable by other async status inputs.

Test Plan (PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=3):
1. Normal lock: locked=1 constant, rst released. Expect pll_rst=1 for edges 1–4, 0 afterwards; ready=1 and sys_rst=0 after edge 13; state=3.
2. No lock: locked=0 throughout. Expect 4 attempts, each 4 cycles of pll_rst=1 then 20 of pll_rst=0; retries steps 0→3; then fail=1, pll_rst=1, state=4. restart then gives fail=0, state=0.
3. Glitchy lock: locked high for 5 cycles in STABLE, then low. Expect return to WAIT_LOCK, retries unchanged, ready stays 0; lock held 8+ cycles then gives RUN.
4. Lock loss in RUN: drop locked for 1 cycle. Expect lock_lost=1, and sys_rst=1 / ready=0 within 3 edges (2 sync + 1 registered); state=0; sequence repeats and ready re-asserts with lock_lost still 1.
5. Simultaneous events: restart coincident with the synchronized lock drop gives HOLD with lock_lost=0. rst asserted mid-STABLE gives all reset values on the next edge.
